// File: rtl/freq_sched_ctrl_if.sv
// Configuration port of freq_sched_ctrl: one period write per valid&&ready transfer.
interface freq_sched_ctrl_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_period;

  modport master (output cfg_valid, output cfg_ch, output cfg_period, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_period, output cfg_ready);
endinterface

// File: rtl/freq_sched_ctrl.sv
// Multi-channel programmable divider / tick scheduler with glitch-free runtime retuning.
// Optional sticky per-channel tick flags are built when FREQ_SCHED_IRQ_EN is defined.
module freq_sched_ctrl #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int RST_PERIOD = 6
) (
  input  logic              clk,
  input  logic              reset,
  freq_sched_ctrl_if.slave  cfg,
  input  logic              sync,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   div_out,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   irq,
  input  logic [N_CH-1:0]   irq_clr
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);

  // Handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
  // cfg_ready is low only while the addressed channel already holds a pending shadow;
  // out-of-range channels are always ready and the transfer is dropped.
  logic             ready;
  logic [N_CH-1:0]  sel;
  logic [N_CH-1:0]  accept;

  always_comb begin
    ready = 1'b1;
    sel   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        ready  = ~pending[i];
        sel[i] = 1'b1;
      end
    end
  end

  assign cfg.cfg_ready = ready;
  assign accept        = sel & {N_CH{cfg.cfg_valid & ready}};

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic             active;
    logic             wrap;
    logic             restart;
    logic             apply;

    assign active  = (per != '0);
    assign wrap    = active && (cnt == per - CNT_W'(1));
    // A disabled channel picks up a shadow at once; a running one only at its wrap.
    assign restart = sync || !active || wrap;
    assign apply   = pend && restart;

    assign tick[g]    = wrap;
    assign div_out[g] = active && (cnt >= per - (per >> 1));
    assign pending[g] = pend;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        per    <= RST_P;
        shadow <= '0;
        pend   <= 1'b0;
      end else begin
        if (restart) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        if (apply) begin
          per <= shadow;
        end
        // Accept requires pend==0, so it never collides with an apply this cycle.
        if (accept[g]) begin
          shadow <= cfg.cfg_period;
          pend   <= 1'b1;
        end else if (apply) begin
          pend <= 1'b0;
        end
      end
    end
  end

`ifdef FREQ_SCHED_IRQ_EN
  logic [N_CH-1:0] irq_q;

  // A tick in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
    end else begin
      irq_q <= tick | (irq_q & ~irq_clr);
    end
  end

  assign irq = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = ^irq_clr;
  assign irq            = '0;
`endif

endmodule

// File: tb/tb_freq_sched_ctrl.sv
// Directed bench for freq_sched_ctrl: cycle k is the k-th falling edge after reset release.
module tb_freq_sched_ctrl;

  localparam int N_CH  = 5;
  localparam int CNT_W = 8;
  localparam int CH_W  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            sync = 1'b0;
  logic [N_CH-1:0] tick;
  logic [N_CH-1:0] div_out;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] irq;
  logic [N_CH-1:0] irq_clr = '0;

  int checks = 0;
  int errors = 0;

  freq_sched_ctrl_if #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W)) cfg_if ();

  freq_sched_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .RST_PERIOD(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg     (cfg_if.slave),
    .sync    (sync),
    .tick    (tick),
    .div_out (div_out),
    .pending (pending),
    .irq     (irq),
    .irq_clr (irq_clr)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sync = 1'b0;
    irq_clr = '0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_period = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (tick !== 5'h00) begin errors++; $display("FAIL reset_tick got=%b exp=%b", tick, 5'h00); end
    checks++;
    if (div_out !== 5'h00) begin errors++; $display("FAIL reset_div got=%b exp=%b", div_out, 5'h00); end
    checks++;
    if (pending !== 5'h00) begin errors++; $display("FAIL reset_pending got=%b exp=%b", pending, 5'h00); end
    checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cfg_if.cfg_ready); end
    checks++;
    if (irq !== 5'h00) begin errors++; $display("FAIL reset_irq got=%b exp=%b", irq, 5'h00); end
  endtask

  task automatic test_default_ticks();
    logic [N_CH-1:0] exp_t, exp_d;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      exp_t = (k % 6 == 5) ? 5'h1f : 5'h00;
      exp_d = (k % 6 >= 3) ? 5'h1f : 5'h00;
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL default_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
      checks++;
      if (div_out !== exp_d) begin errors++; $display("FAIL default_div k=%0d got=%b exp=%b", k, div_out, exp_d); end
    end
  endtask

  task automatic test_retune();
    logic exp_p, exp_t, exp_d, exp_t0;
    do_reset();
    for (int k = 0; k < 18; k++) begin
      if (k != 0) @(negedge clk);
      cfg_if.cfg_valid = (k == 2);
      cfg_if.cfg_ch = 3'd1;
      cfg_if.cfg_period = 8'd4;
      #1;
      if (k == 2) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL retune_ready got=%b exp=1", cfg_if.cfg_ready); end
      end
      exp_p  = (k >= 3 && k <= 5);
      exp_t  = (k < 6) ? (k == 5) : ((k - 6) % 4 == 3);
      exp_d  = (k < 6) ? (k >= 3) : ((k - 6) % 4 >= 2);
      exp_t0 = (k % 6 == 5);
      checks++;
      if (pending !== {3'b000, exp_p, 1'b0}) begin errors++; $display("FAIL retune_pending k=%0d got=%b exp=%b", k, pending, {3'b000, exp_p, 1'b0}); end
      checks++;
      if (tick[1] !== exp_t) begin errors++; $display("FAIL retune_tick1 k=%0d got=%b exp=%b", k, tick[1], exp_t); end
      checks++;
      if (div_out[1] !== exp_d) begin errors++; $display("FAIL retune_div1 k=%0d got=%b exp=%b", k, div_out[1], exp_d); end
      checks++;
      if (tick[0] !== exp_t0) begin errors++; $display("FAIL retune_tick0 k=%0d got=%b exp=%b", k, tick[0], exp_t0); end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_disable_stall();
    logic exp_r, exp_p, exp_t, exp_d;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      if (k != 0) @(negedge clk);
      cfg_if.cfg_valid = (k <= 6);
      cfg_if.cfg_ch = 3'd2;
      cfg_if.cfg_period = (k == 0) ? 8'd0 : 8'd3;
      #1;
      if (k <= 6) begin
        exp_r = (k == 0 || k == 6);
        checks++;
        if (cfg_if.cfg_ready !== exp_r) begin errors++; $display("FAIL stall_ready k=%0d got=%b exp=%b", k, cfg_if.cfg_ready, exp_r); end
      end
      exp_p = (k >= 1 && k <= 5) || (k == 7);
      if (k <= 5)      begin exp_t = (k == 5);            exp_d = (k >= 3); end
      else if (k <= 7) begin exp_t = 1'b0;                exp_d = 1'b0; end
      else             begin exp_t = ((k - 8) % 3 == 2);  exp_d = ((k - 8) % 3 == 2); end
      checks++;
      if (pending[2] !== exp_p) begin errors++; $display("FAIL stall_pending k=%0d got=%b exp=%b", k, pending[2], exp_p); end
      checks++;
      if (tick[2] !== exp_t) begin errors++; $display("FAIL stall_tick2 k=%0d got=%b exp=%b", k, tick[2], exp_t); end
      checks++;
      if (div_out[2] !== exp_d) begin errors++; $display("FAIL stall_div2 k=%0d got=%b exp=%b", k, div_out[2], exp_d); end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_sync();
    logic exp_p, exp_t0, exp_d0, exp_t1;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      if (k != 0) @(negedge clk);
      cfg_if.cfg_valid = (k == 0);
      cfg_if.cfg_ch = 3'd0;
      cfg_if.cfg_period = 8'd10;
      sync = (k == 3);
      #1;
      exp_p  = (k >= 1 && k <= 3);
      exp_t0 = (k >= 4) && (k - 4 == 9);
      exp_d0 = (k < 4) ? (k >= 3) : (k - 4 >= 5);
      exp_t1 = (k >= 4) && ((k - 4) % 6 == 5);
      checks++;
      if (pending[0] !== exp_p) begin errors++; $display("FAIL sync_pending k=%0d got=%b exp=%b", k, pending[0], exp_p); end
      checks++;
      if (tick[0] !== exp_t0) begin errors++; $display("FAIL sync_tick0 k=%0d got=%b exp=%b", k, tick[0], exp_t0); end
      checks++;
      if (div_out[0] !== exp_d0) begin errors++; $display("FAIL sync_div0 k=%0d got=%b exp=%b", k, div_out[0], exp_d0); end
      checks++;
      if (tick[1] !== exp_t1) begin errors++; $display("FAIL sync_tick1 k=%0d got=%b exp=%b", k, tick[1], exp_t1); end
    end
    cfg_if.cfg_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic test_out_of_range_and_reset();
    logic [N_CH-1:0] exp_t;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      cfg_if.cfg_valid = (k <= 2);
      cfg_if.cfg_ch = (k == 0) ? 3'd5 : ((k == 1) ? 3'd7 : 3'd3);
      cfg_if.cfg_period = (k == 0) ? 8'd1 : ((k == 1) ? 8'd0 : 8'd2);
      #1;
      if (k <= 2) begin
        checks++;
        if (cfg_if.cfg_ready !== 1'b1) begin errors++; $display("FAIL oor_ready k=%0d got=%b exp=1", k, cfg_if.cfg_ready); end
      end
      checks++;
      if (pending !== ((k == 3) ? 5'b01000 : 5'b00000)) begin errors++; $display("FAIL oor_pending k=%0d got=%b", k, pending); end
      checks++;
      if (tick !== 5'h00) begin errors++; $display("FAIL oor_tick k=%0d got=%b exp=00000", k, tick); end
    end
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      exp_t = (k % 6 == 5) ? 5'h1f : 5'h00;
      checks++;
      if (pending !== 5'h00) begin errors++; $display("FAIL rst_pending k=%0d got=%b exp=00000", k, pending); end
      checks++;
      if (tick !== exp_t) begin errors++; $display("FAIL rst_tick k=%0d got=%b exp=%b", k, tick, exp_t); end
    end
  endtask

`ifdef FREQ_SCHED_IRQ_EN
  task automatic test_irq();
    logic [N_CH-1:0] exp_i;
    logic            i0, i_other;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      if (k != 0) @(negedge clk);
      cfg_if.cfg_valid = (k == 0);
      cfg_if.cfg_ch = 3'd4;
      cfg_if.cfg_period = 8'd1;
      sync = (k == 1);
      irq_clr = {(k >= 3), 3'b000, (k == 9)};
      #1;
      i0      = (k == 8) || (k == 9) || (k >= 14);
      i_other = (k >= 8);
      exp_i   = {(k >= 3), i_other, i_other, i_other, i0};
      checks++;
      if (irq !== exp_i) begin errors++; $display("FAIL irq k=%0d got=%b exp=%b", k, irq, exp_i); end
      checks++;
      if (tick[4] !== (k >= 2)) begin errors++; $display("FAIL irq_tick4 k=%0d got=%b exp=%b", k, tick[4], (k >= 2)); end
    end
    cfg_if.cfg_valid = 1'b0;
    sync = 1'b0;
    irq_clr = '0;
  endtask
`else
  task automatic test_irq();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k != 0) @(negedge clk);
      irq_clr = (k % 2 == 0) ? 5'h1f : 5'h00;
      #1;
      checks++;
      if (irq !== 5'h00) begin errors++; $display("FAIL irq_tied k=%0d got=%b exp=00000", k, irq); end
      checks++;
      if (tick !== ((k % 6 == 5) ? 5'h1f : 5'h00)) begin errors++; $display("FAIL irq_tied_tick k=%0d got=%b", k, tick); end
    end
    irq_clr = '0;
  endtask
`endif

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch = '0;
    cfg_if.cfg_period = '0;
    test_reset();
    test_default_ticks();
    test_retune();
    test_disable_stall();
    test_sync();
    test_out_of_range_and_reset();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
